// File: rtl/monitor_uart_tx_if.sv
// Bundle between the snapshot monitor and the Nano monitor mux: select out, byte/nibble back.
// Latency: none; this is plain wiring.
// Backpressure: none; the mux is purely combinational.
interface monitor_uart_tx_if;
  logic [2:0] OUT_CTRL;
  logic [7:0] OUT8B;
  logic [3:0] OUT4B;

  // master drives the select and reads the mux data
  modport master (output OUT_CTRL, input OUT8B, input OUT4B);
  // slave is the monitor mux itself
  modport slave  (input OUT_CTRL, output OUT8B, output OUT4B);
endinterface

// File: rtl/monitor_uart_tx.sv
// Snapshot the monitor mux (status, R word, flags) and stream it as an 8-byte checksummed 8N1 UART frame.
// Latency: TXD start bit begins 10 cycles after START is accepted; frame lasts 80*CLK_DIV cycles.
// Backpressure: none; START is ignored while BUSY, there is no request queue.
module monitor_uart_tx #(
  parameter int CLK_DIV = 163
) (
  input  logic               CLK,
  input  logic               NRST,
  input  logic               START,
  input  logic [2:0]         IDLE_CTRL,
  monitor_uart_tx_if.master  mon,
  output logic               TXD,
  output logic               BUSY,
  output logic               FRAME_DONE
);

  typedef enum logic [2:0] {
    IDLE, CAP_SET, CAP_SMP, TX_START, TX_DATA, TX_STOP
  } state_t;

  localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

  state_t      state, state_d;
  logic [2:0]  cap_idx, nxt_cap;
  logic [2:0]  byte_idx;
  logic [2:0]  bit_idx, nxt_bit;
  logic [9:0]  bit_cnt;
  logic        tick;
  logic [7:0]  st, fl;
  logic [31:0] r;
  logic [7:0]  chk, cur_byte;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;

  // Mux select code for each capture step: status, then R bytes 0..3 (flags ride on OUT4B).
  function automatic logic [2:0] cap_code(input logic [2:0] i);
    case (i)
      3'd0:    cap_code = 3'd0;
      3'd1:    cap_code = 3'd4;
      3'd2:    cap_code = 3'd5;
      3'd3:    cap_code = 3'd6;
      default: cap_code = 3'd7;
    endcase
  endfunction

  assign tick = (bit_cnt == 10'd0);
  assign chk  = st ^ r[7:0] ^ r[15:8] ^ r[23:16] ^ r[31:24] ^ fl;

  // Byte currently on the wire, selected by frame position; header is outside the checksum.
  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      3'd0: cur_byte = 8'hA5;
      3'd1: cur_byte = st;
      3'd2: cur_byte = r[7:0];
      3'd3: cur_byte = r[15:8];
      3'd4: cur_byte = r[23:16];
      3'd5: cur_byte = r[31:24];
      3'd6: cur_byte = fl;
      default: cur_byte = chk;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic: capture walk, then start/data/stop per byte until the checksum byte ends.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (START) state_d = CAP_SET;
      CAP_SET:  state_d = CAP_SMP;
      CAP_SMP:  state_d = (cap_idx == 3'd4) ? TX_START : CAP_SET;
      TX_START: if (tick) state_d = TX_DATA;
      TX_DATA:  if (tick && bit_idx == 3'd7) state_d = TX_STOP;
      TX_STOP:  if (tick) state_d = (byte_idx == 3'd7) ? IDLE : TX_START;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode: next registered select, next line level and the completion pulse.
  always_comb begin
    case (state)
      IDLE:    nxt_cap = 3'd0;
      CAP_SMP: nxt_cap = cap_idx + 3'd1;
      default: nxt_cap = cap_idx;
    endcase
    if (state == TX_DATA) nxt_bit = tick ? bit_idx + 3'd1 : bit_idx;
    else                  nxt_bit = 3'd0;

    ctrl_d = 3'b111;
    if (state_d == CAP_SET || state_d == CAP_SMP) ctrl_d = cap_code(nxt_cap);

    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = cur_byte[nxt_bit];
      default:  txd_d = 1'b1;
    endcase

    done_d = (state == TX_STOP) && (state_d == IDLE);
  end

  // Datapath: capture registers, bit timer and frame position counters.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      cap_idx  <= 3'd0;
      byte_idx <= 3'd0;
      bit_idx  <= 3'd0;
      bit_cnt  <= DIV_M1;
      st       <= 8'h00;
      fl       <= 8'h00;
      r        <= 32'h0;
      ctrl_q   <= 3'd0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      cap_idx <= nxt_cap;
      bit_idx <= nxt_bit;
      ctrl_q  <= ctrl_d;
      txd_q   <= txd_d;
      done_q  <= done_d;

      if (state == TX_START || state == TX_DATA || state == TX_STOP)
        bit_cnt <= tick ? DIV_M1 : bit_cnt - 10'd1;
      else
        bit_cnt <= DIV_M1;

      if (state == CAP_SMP)                 byte_idx <= 3'd0;
      else if (state == TX_STOP && tick)    byte_idx <= byte_idx + 3'd1;

      if (state == CAP_SMP) begin
        case (cap_idx)
          3'd0: st <= mon.OUT8B;
          3'd1: begin r[7:0]   <= mon.OUT8B; fl[3:0] <= mon.OUT4B; end
          3'd2: r[15:8]  <= mon.OUT8B;
          3'd3: begin r[23:16] <= mon.OUT8B; fl[7:4] <= mon.OUT4B; end
          default: r[31:24] <= mon.OUT8B;
        endcase
      end
    end
  end

  // Live passthrough while idle keeps the monitor usable when no snapshot is running.
  assign mon.OUT_CTRL = (state == IDLE) ? IDLE_CTRL : ctrl_q;
  assign TXD          = txd_q;
  assign BUSY         = (state != IDLE);
  assign FRAME_DONE   = done_q;

endmodule

// File: tb/tb_monitor_uart_tx.sv
// Bench for monitor_uart_tx: random snapshot sources, a mux model and a line-level frame reference.
// Latency: checks select walk, start-bit edge at E10 and FRAME_DONE at E10+80*CLK_DIV.
// Backpressure: checks START is ignored mid-frame and re-accepted in the FRAME_DONE cycle.
module tb_monitor_uart_tx;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        start;
  logic        dsel;
  logic [2:0]  idle_ctrl;
  logic [7:0]  src_st, src_fl;
  logic [31:0] src_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  monitor_uart_tx_if mon_a ();
  monitor_uart_tx_if mon_b ();

  logic txd_a, busy_a, done_a, txd_b, busy_b, done_b;
  logic start_a, start_b;
  assign start_a = start & ~dsel;
  assign start_b = start & dsel;

  monitor_uart_tx #(.CLK_DIV(4)) dut_a (
    .CLK(CLK), .NRST(NRST), .START(start_a), .IDLE_CTRL(idle_ctrl),
    .mon(mon_a.master), .TXD(txd_a), .BUSY(busy_a), .FRAME_DONE(done_a)
  );

  monitor_uart_tx #(.CLK_DIV(163)) dut_b (
    .CLK(CLK), .NRST(NRST), .START(start_b), .IDLE_CTRL(idle_ctrl),
    .mon(mon_b.master), .TXD(txd_b), .BUSY(busy_b), .FRAME_DONE(done_b)
  );

  // Monitor mux model: code 0 status, 4..7 R bytes, flag nibbles on codes 4 and 6.
  function automatic logic [7:0] mux8(input logic [2:0] c, input logic [7:0] st, input logic [31:0] r);
    case (c)
      3'd0:    mux8 = st;
      3'd4:    mux8 = r[7:0];
      3'd5:    mux8 = r[15:8];
      3'd6:    mux8 = r[23:16];
      3'd7:    mux8 = r[31:24];
      default: mux8 = 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] mux4(input logic [2:0] c, input logic [7:0] fl);
    case (c)
      3'd4:    mux4 = fl[3:0];
      3'd6:    mux4 = fl[7:4];
      default: mux4 = 4'h0;
    endcase
  endfunction

  assign mon_a.OUT8B = mux8(mon_a.OUT_CTRL, src_st, src_r);
  assign mon_a.OUT4B = mux4(mon_a.OUT_CTRL, src_fl);
  assign mon_b.OUT8B = mux8(mon_b.OUT_CTRL, src_st, src_r);
  assign mon_b.OUT4B = mux4(mon_b.OUT_CTRL, src_fl);

  logic       obs_txd, obs_busy, obs_done;
  logic [2:0] obs_ctrl;
  assign obs_txd  = dsel ? txd_b  : txd_a;
  assign obs_busy = dsel ? busy_b : busy_a;
  assign obs_done = dsel ? done_b : done_a;
  assign obs_ctrl = dsel ? mon_b.OUT_CTRL : mon_a.OUT_CTRL;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete frame. chg = cycle in which the R source switches to r_new (>=1000: never).
  // hold keeps START high throughout; already means START was accepted-ready from the prior frame.
  task automatic run_frame(input int div, input logic [7:0] st, input logic [31:0] r,
                           input logic [7:0] fl, input int chg, input logic [31:0] r_new,
                           input bit hold, input bit already);
    logic [7:0] frm [8];
    logic [7:0] dec [8];
    logic [2:0] seq [10];
    int         cap_edge [4];
    int         total, n, slot, b, j;
    int         e_line, e_ctrl, e_busy, e_done;
    logic       lvl;
    logic [7:0] rb;
    seq      = '{3'd0, 3'd0, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
    cap_edge = '{4, 6, 8, 10};
    e_line = 0; e_ctrl = 0; e_busy = 0; e_done = 0;
    src_st = st; src_r = r; src_fl = fl;
    idle_ctrl = 3'($urandom_range(0, 7));

    // Reference frame: each R byte is whatever the source held at its sampling edge.
    frm[0] = 8'hA5;
    frm[1] = st;
    for (int k = 0; k < 4; k++) begin
      rb = (cap_edge[k] >= chg) ? r_new[8*k +: 8] : r[8*k +: 8];
      frm[2 + k] = rb;
    end
    frm[6] = fl;
    frm[7] = frm[1] ^ frm[2] ^ frm[3] ^ frm[4] ^ frm[5] ^ frm[6];
    for (int k = 0; k < 8; k++) dec[k] = 8'h00;

    if (!already) start = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) start = 1'b0;
    total = 10 + 80 * div + 1;
    for (int c = 1; c <= total; c++) begin
      @(negedge CLK);
      if (c == chg) src_r = r_new;
      if (!hold && (c == 5 || c == 50)) start = 1'b1;
      if (!hold && (c == 6 || c == 51)) start = 1'b0;
      if (c <= 10) begin
        chk($sformatf("ctrl_c%0d", c), 32'(obs_ctrl), 32'(seq[c - 1]));
        if (obs_txd !== 1'b1) e_line++;
      end else if (c < total) begin
        n    = c - 11;
        slot = n / div;
        b    = slot / 10;
        j    = slot % 10;
        if (j == 0)      lvl = 1'b0;
        else if (j == 9) lvl = 1'b1;
        else             lvl = frm[b][j - 1];
        if (obs_txd !== lvl) e_line++;
        if ((n % div) == (div / 2) && j >= 1 && j <= 8) dec[b][j - 1] = obs_txd;
        if (obs_ctrl !== 3'b111) e_ctrl++;
      end
      if (c < total) begin
        if (obs_busy !== 1'b1) e_busy++;
        if (obs_done !== 1'b0) e_done++;
      end else begin
        chk("done_at_end", 32'(obs_done), 32'd1);
        chk("busy_at_end", 32'(obs_busy), 32'd0);
        chk("ctrl_at_end", 32'(obs_ctrl), 32'(idle_ctrl));
        chk("txd_at_end",  32'(obs_txd),  32'd1);
      end
    end
    chk("line_timing_errs", 32'(e_line), 32'd0);
    chk("tx_ctrl_errs",     32'(e_ctrl), 32'd0);
    chk("busy_errs",        32'(e_busy), 32'd0);
    chk("early_done_errs",  32'(e_done), 32'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("byte%0d", k), 32'(dec[k]), 32'(frm[k]));
  endtask

  task automatic after_idle_check(input string tag);
    @(negedge CLK);
    chk({tag, "_done_low"}, 32'(obs_done), 32'd0);
    chk({tag, "_busy_low"}, 32'(obs_busy), 32'd0);
  endtask

  // Bound on total run time regardless of DUT behaviour.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dsel = 1'b0; start = 1'b0; idle_ctrl = 3'd3; NRST = 1'b0;
    src_st = 8'h00; src_r = 32'h0; src_fl = 8'h00;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_txd",  32'(txd_a),          32'd1);
    chk("rst_busy", 32'(busy_a),         32'd0);
    chk("rst_done", 32'(done_a),         32'd0);
    chk("rst_ctrl", 32'(mon_a.OUT_CTRL), 32'd3);
    chk("rst_txd_b", 32'(txd_b),         32'd1);
    NRST = 1'b1;
    @(negedge CLK);
    chk("idle_ctrl_3", 32'(mon_a.OUT_CTRL), 32'd3);
    idle_ctrl = 3'd5;
    #1;
    chk("idle_ctrl_5", 32'(mon_a.OUT_CTRL), 32'd5);
    chk("idle_busy",   32'(busy_a),         32'd0);

    // Directed basic frame
    @(negedge CLK);
    run_frame(4, 8'h12, 32'hDEADBEEF, 8'h3C, 1000, 32'h0, 1'b0, 1'b0);
    after_idle_check("basic");

    // Random frames
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge CLK);
      run_frame(4, 8'($urandom), $urandom, 8'($urandom), 1000, 32'h0, 1'b0, 1'b0);
      after_idle_check($sformatf("rand%0d", i));
    end

    // R source cleared after idx2 sampled (E6)
    @(negedge CLK);
    run_frame(4, 8'($urandom), 32'hDEADBEEF, 8'($urandom), 7, 32'h0, 1'b0, 1'b0);
    after_idle_check("srcchg");

    // START held high: back-to-back frames
    @(negedge CLK);
    start = 1'b1;
    run_frame(4, 8'($urandom), $urandom, 8'($urandom), 1000, 32'h0, 1'b1, 1'b0);
    run_frame(4, 8'($urandom), $urandom, 8'($urandom), 1000, 32'h0, 1'b0, 1'b1);
    after_idle_check("held");

    // Reset during the data bits of the third byte (R0=EF, bit4 low at cycle 112)
    @(negedge CLK);
    src_st = 8'($urandom); src_r = 32'hDEADBEEF; src_fl = 8'($urandom);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (112) @(negedge CLK);
    chk("pre_rst_txd", 32'(txd_a), 32'd0);
    NRST = 1'b0;
    #1;
    chk("async_rst_txd",  32'(txd_a),  32'd1);
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_done", 32'(done_a), 32'd0);
    @(negedge CLK);
    NRST = 1'b1;
    @(negedge CLK);
    run_frame(4, 8'($urandom), $urandom, 8'($urandom), 1000, 32'h0, 1'b0, 1'b0);
    after_idle_check("post_rst");

    // Full bit timing at CLK_DIV=163
    @(negedge CLK);
    dsel = 1'b1;
    @(negedge CLK);
    run_frame(163, 8'($urandom), $urandom, 8'($urandom), 1000, 32'h0, 1'b0, 1'b0);
    after_idle_check("div163");
    dsel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
